// File: rtl/pointwise_convolve_folded.sv
// Folded 1x1 convolution stage: ParallelOut output channels are issued per cycle, then biased,
// requantised, optionally rectified and saturated. Weight/Bias are flat vectors, element [0][0] at MSB.
module pointwise_convolve_folded #(
  parameter int InChannels      = 147,
  parameter int OutChannels     = 16,
  parameter int ParallelOut     = 4,
  parameter int ActivationWidth = 8,
  parameter int WeightWidth     = 8,
  parameter int BiasWidth       = 32,
  parameter logic [OutChannels*InChannels*WeightWidth-1:0] Weight = '0,
  parameter logic [OutChannels*BiasWidth-1:0]              Bias   = '0,
  parameter int Shift           = 7,
  parameter bit EnableReLU      = 1'b1,
  parameter int PipelineStages  = 2
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic                                   slave_valid_i,
  output logic                                   slave_ready_o,
  input  logic [InChannels*ActivationWidth-1:0]  slave_data_i,
  output logic                                   master_valid_o,
  input  logic                                   master_ready_i,
  output logic [OutChannels*ActivationWidth-1:0] master_data_o
);

  localparam int Groups     = OutChannels / ParallelOut;
  localparam int SumWidth   = ActivationWidth + WeightWidth + $clog2(InChannels);
  localparam int AccWidth   = ((SumWidth > BiasWidth) ? SumWidth : BiasWidth) + 1;
  localparam int GroupWidth = (Groups > 1) ? $clog2(Groups) : 1;
  localparam int CountWidth = $clog2(Groups + PipelineStages + 1) + 1;
  localparam int SliceWidth = ParallelOut * ActivationWidth;

  localparam logic [CountWidth-1:0] GroupsCount = CountWidth'(Groups);
  localparam logic [CountWidth-1:0] DoneCount   = CountWidth'(Groups + PipelineStages);

  localparam logic signed [AccWidth:0] RoundConst =
    (Shift > 0) ? ((AccWidth+1)'(1) << ((Shift > 0) ? Shift - 1 : 0)) : '0;
  localparam logic signed [AccWidth:0] MaxVal = (AccWidth+1)'((1 << (ActivationWidth - 1)) - 1);
  localparam logic signed [AccWidth:0] MinVal = -MaxVal - (AccWidth+1)'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  if (OutChannels % ParallelOut != 0) begin : g_bad_fold
    $error("OutChannels must be a multiple of ParallelOut");
  end

  function automatic logic signed [AccWidth-1:0] weight_at(input int o, input int i);
    return AccWidth'($signed(Weight[(OutChannels*InChannels - 1 - (o*InChannels + i))*WeightWidth +: WeightWidth]));
  endfunction

  function automatic logic signed [AccWidth-1:0] bias_at(input int o);
    return AccWidth'($signed(Bias[(OutChannels - 1 - o)*BiasWidth +: BiasWidth]));
  endfunction

  // Round half up, optional ReLU, then clamp into the activation range.
  function automatic logic [ActivationWidth-1:0] requant(input logic signed [AccWidth-1:0] acc);
    logic signed [AccWidth:0] r;
    r = ($signed({acc[AccWidth-1], acc}) + RoundConst) >>> Shift;
    if (EnableReLU && r[AccWidth]) r = '0;
    if (r > MaxVal) r = MaxVal;
    else if (r < MinVal) r = MinVal;
    return r[ActivationWidth-1:0];
  endfunction

  logic [1:0]                            state_reg;
  logic [CountWidth-1:0]                 count_reg;
  logic [InChannels*ActivationWidth-1:0] vector_reg;

  logic                  issue_valid;
  logic [GroupWidth-1:0] issue_group;
  logic [SliceWidth-1:0] issue_data;
  logic                  wb_valid;
  logic [GroupWidth-1:0] wb_group;
  logic [SliceWidth-1:0] wb_data;

  assign slave_ready_o  = (state_reg == IDLE);
  assign master_valid_o = (state_reg == OUTPUT);
  assign issue_valid    = (state_reg == COMPUTE) && (count_reg < GroupsCount);
  assign issue_group    = count_reg[GroupWidth-1:0];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      vector_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (slave_valid_i) begin
            vector_reg <= slave_data_i;
            count_reg  <= '0;
            state_reg  <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Leave one edge after the final writeback so valid rises on a settled buffer.
          if (count_reg == DoneCount) state_reg <= OUTPUT;
          else count_reg <= count_reg + CountWidth'(1);
        end
        OUTPUT: begin
          if (master_ready_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < ParallelOut; gi++) begin : g_lane
    logic signed [AccWidth-1:0] acc;
    always_comb begin
      acc = bias_at(int'(issue_group) * ParallelOut + gi);
      for (int i = 0; i < InChannels; i++) begin
        acc = acc + AccWidth'($signed(vector_reg[(InChannels-1-i)*ActivationWidth +: ActivationWidth]))
                  * weight_at(int'(issue_group) * ParallelOut + gi, i);
      end
    end
    assign issue_data[(ParallelOut-1-gi)*ActivationWidth +: ActivationWidth] = requant(acc);
  end

  if (PipelineStages == 0) begin : g_direct
    assign wb_valid = issue_valid;
    assign wb_group = issue_group;
    assign wb_data  = issue_data;
  end else begin : g_pipe
    logic                  pipe_valid [PipelineStages];
    logic [GroupWidth-1:0] pipe_group [PipelineStages];
    logic [SliceWidth-1:0] pipe_data  [PipelineStages];

    always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
        for (int k = 0; k < PipelineStages; k++) begin
          pipe_valid[k] <= 1'b0;
          pipe_group[k] <= '0;
          pipe_data[k]  <= '0;
        end
      end else begin
        pipe_valid[0] <= issue_valid;
        pipe_group[0] <= issue_group;
        pipe_data[0]  <= issue_data;
        for (int k = 1; k < PipelineStages; k++) begin
          pipe_valid[k] <= pipe_valid[k-1];
          pipe_group[k] <= pipe_group[k-1];
          pipe_data[k]  <= pipe_data[k-1];
        end
      end
    end

    assign wb_valid = pipe_valid[PipelineStages-1];
    assign wb_group = pipe_group[PipelineStages-1];
    assign wb_data  = pipe_data[PipelineStages-1];
  end

  // Group g occupies channels [g*ParallelOut +: ParallelOut], channel 0 at the MSB end.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      master_data_o <= '0;
    end else if (wb_valid) begin
      master_data_o[(OutChannels - (int'(wb_group) + 1) * ParallelOut) * ActivationWidth +: SliceWidth] <= wb_data;
    end
  end

endmodule

// File: tb/tb_pointwise_convolve_folded.sv
// Six differently configured instances run in lockstep on one stimulus stream; each output is
// compared against a behavioural model fed from a scoreboard of accepted input vectors.
module tb_pointwise_convolve_folded;

  localparam int NumDut = 6;

  function automatic int cfg_weight(input int d, input int o, input int i);
    case (d)
      2:       return 127;
      3:       return -128;
      5:       return ((o*37 + i*23) % 255) - 127;
      default: return (o == i) ? 1 : 0;
    endcase
  endfunction

  function automatic int cfg_bias(input int d, input int o);
    case (d)
      4:       return 2 - o;
      5:       return o*1000 - 1500;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_shift(input int d);
    return (d == 4) ? 2 : (d == 5) ? 6 : 0;
  endfunction

  function automatic int cfg_relu(input int d);
    return (d == 1 || d == 5) ? 1 : 0;
  endfunction

  function automatic logic [127:0] weight_flat(input int d);
    logic [127:0] f;
    f = '0;
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 4; i++)
        f[(15 - (o*4 + i))*8 +: 8] = 8'(cfg_weight(d, o, i));
    return f;
  endfunction

  function automatic logic [127:0] bias_flat(input int d);
    logic [127:0] f;
    f = '0;
    for (int o = 0; o < 4; o++) f[(3 - o)*32 +: 32] = 32'(cfg_bias(d, o));
    return f;
  endfunction

  function automatic logic [31:0] model(input int d, input logic [31:0] x);
    logic [31:0] y;
    longint acc;
    int s;
    y = '0;
    s = cfg_shift(d);
    for (int o = 0; o < 4; o++) begin
      acc = cfg_bias(d, o);
      for (int i = 0; i < 4; i++) begin
        logic signed [7:0] xi;
        xi = x[(3 - i)*8 +: 8];
        acc += longint'(xi) * cfg_weight(d, o, i);
      end
      if (s > 0) acc += longint'(1) << (s - 1);
      acc = acc >>> s;
      if (cfg_relu(d) != 0 && acc < 0) acc = 0;
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
      y[(3 - o)*8 +: 8] = 8'(acc);
    end
    return y;
  endfunction

  logic clock;
  logic reset_n;
  logic slave_valid;
  logic [31:0] slave_data;
  logic master_ready;
  logic [NumDut-1:0] slave_ready;
  logic [NumDut-1:0] master_valid;
  logic [NumDut-1:0][31:0] master_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NumDut; gi++) begin : g_dut
    pointwise_convolve_folded #(
      .InChannels(4), .OutChannels(4), .ParallelOut(2),
      .ActivationWidth(8), .WeightWidth(8), .BiasWidth(32),
      .Weight(weight_flat(gi)), .Bias(bias_flat(gi)),
      .Shift(cfg_shift(gi)), .EnableReLU(cfg_relu(gi) != 0), .PipelineStages(2)
    ) dut (
      .clock_i(clock),
      .reset_i(reset_n),
      .slave_valid_i(slave_valid),
      .slave_ready_o(slave_ready[gi]),
      .slave_data_i(slave_data),
      .master_valid_o(master_valid[gi]),
      .master_ready_i(master_ready),
      .master_data_o(master_data[gi])
    );
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] x, output int acc_cyc);
    int n;
    n = 0;
    slave_data  = x;
    slave_valid = 1'b1;
    while (slave_ready !== '1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("accept_wait", 192'(n < 50), 192'(1));
    @(posedge clock); #1;
    acc_cyc     = cyc;
    slave_valid = 1'b0;
    slave_data  = $urandom;
    exp_q.push_back(x);
    $display("send x=%h at cycle %0d", x, acc_cyc);
  endtask

  task automatic receive(input int pause, input int acc_cyc, output logic [NumDut-1:0][31:0] got);
    int n;
    logic [31:0] x;
    n = 0;
    master_ready = 1'b0;
    while (master_valid[0] !== 1'b1 && n < 50) begin
      check("ready_low_busy", 192'(slave_ready), 192'(0));
      @(posedge clock); #1;
      n++;
    end
    check("valid_latency", 192'(cyc - acc_cyc), 192'(5));
    check("valid_all", 192'(master_valid), 192'({NumDut{1'b1}}));
    got = master_data;
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 192'(0), 192'(1));
      x = '0;
    end else begin
      x = exp_q.pop_front();
    end
    for (int d = 0; d < NumDut; d++)
      check($sformatf("data_dut%0d", d), 192'(master_data[d]), 192'(model(d, x)));
    repeat (pause) begin
      @(posedge clock); #1;
      check("hold_data", 192'(master_data), 192'(got));
      check("hold_valid", 192'(master_valid), 192'({NumDut{1'b1}}));
      check("hold_ready_low", 192'(slave_ready), 192'(0));
    end
    master_ready = 1'b1;
    @(posedge clock); #1;
    master_ready = 1'b0;
    check("valid_drop", 192'(master_valid), 192'(0));
    check("ready_idle", 192'(slave_ready), 192'({NumDut{1'b1}}));
    $display("recv x=%h dut0=%h dut5=%h pause=%0d", x, got[0], got[5], pause);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [NumDut-1:0][31:0] got;
    logic [31:0] y;

    reset_n = 1'b0;
    slave_valid = 1'b0;
    slave_data = '0;
    master_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", 192'(master_valid), 192'(0));
    check("reset_data", 192'(master_data), 192'(0));
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("reset_ready", 192'(slave_ready), 192'({NumDut{1'b1}}));

    // Identity, with and without ReLU.
    send(32'h01FE03FC, acc);
    receive(0, acc, got);
    check("t1_identity", 192'(got[0]), 192'(32'h01FE03FC));
    check("t2_relu", 192'(got[1]), 192'(32'h01000300));

    // Saturation high and low.
    send(32'h7F7F7F7F, acc);
    receive(0, acc, got);
    check("t3_sat_high", 192'(got[2]), 192'(32'h7F7F7F7F));
    check("t3_sat_low", 192'(got[3]), 192'(32'h80808080));

    // Bias plus rounding shift.
    send(32'h04050607, acc);
    receive(0, acc, got);
    check("t4_round", 192'(got[4]), 192'(32'h02020202));

    // Downstream stalls for 10 cycles.
    send(32'h9C3A7F80, acc);
    receive(10, acc, got);

    // Valid held through COMPUTE/OUTPUT, then a handshake coinciding with a waiting vector.
    send(32'h11223344, acc);
    y = 32'hF0E1D2C3;
    slave_valid = 1'b1;
    slave_data  = y;
    receive(3, acc, got);
    @(posedge clock); #1;
    acc = cyc;
    slave_valid = 1'b0;
    slave_data  = '0;
    exp_q.push_back(y);
    check("overlap_accepted", 192'(slave_ready), 192'(0));
    receive(0, acc, got);

    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 10)) @(posedge clock);
      #1;
      send($urandom, acc);
      receive($urandom_range(0, 10), acc, got);
    end

    // Reset two cycles into COMPUTE discards the vector.
    send(32'h55AA33CC, acc);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 192'(master_valid), 192'(0));
    check("midreset_data", 192'(master_data), 192'(0));
    void'(exp_q.pop_back());
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      check("postreset_no_valid", 192'(master_valid), 192'(0));
    end
    check("postreset_ready", 192'(slave_ready), 192'({NumDut{1'b1}}));
    send(32'h0A0B0C0D, acc);
    receive(2, acc, got);
    check("postreset_identity", 192'(got[0]), 192'(32'h0A0B0C0D));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
